// File: rtl/uart_alu_top.sv
// uart_alu_top: UART byte receiver feeding a small packet ALU whose
// responses are sent back through a 2-entry FIFO and a UART transmitter.
//
// Parameters:
//   PRESCALE - clk cycles per 1/8 bit (clk_freq / (baud * 8)).
// Ports:
//   clk  - system clock, all logic on the rising edge
//   rst  - asynchronous active-low reset
//   rx_i - UART serial input (8N1, LSB first, idle high)
//   tx_o - UART serial output (8N1, LSB first, idle high)
// Packet: opcode, reserved, length lo, length hi (total length including
// the 4-byte header), then payload. 0xEC echoes the payload; 0xA0 sums
// 32-bit little-endian operands and returns the 4-byte result.
// Optional feature: define UART_ALU_MUL_EN to enable opcode 0x88, which
// multiplies the operands (low 32 bits kept, empty product is 1).
module uart_alu_top #(
  parameter logic [15:0] PRESCALE = 16'h0035
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  localparam logic [18:0] BIT_CYC  = {PRESCALE, 3'b000};
  localparam logic [18:0] HALF_CYC = {1'b0, PRESCALE, 2'b00};

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'h88;

`ifdef UART_ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  localparam logic [2:0] ST_OPCODE  = 3'd0;
  localparam logic [2:0] ST_RSVD    = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_LEN_HI  = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_RESULT  = 3'd5;

  // ---------------- receiver ----------------
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic        rx_busy_reg, rx_valid_reg;
  logic [18:0] rx_cnt_reg;
  logic [3:0]  rx_idx_reg;
  logic [7:0]  rx_data_reg;

  // Start requires a real high-to-low edge, so a line still low after a
  // frame error is not mistaken for a new start bit.
  wire rx_fall = rx_prev_reg & ~rx_sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_busy_reg  <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_data_reg  <= '0;
    end else begin
      rx_meta_reg  <= rx_i;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_valid_reg <= 1'b0;
      if (!rx_busy_reg) begin
        if (rx_fall) begin
          rx_busy_reg <= 1'b1;
          rx_cnt_reg  <= HALF_CYC - 19'd1;  // land on mid start bit
          rx_idx_reg  <= 4'd0;
        end
      end else if (rx_cnt_reg != '0) begin
        rx_cnt_reg <= rx_cnt_reg - 19'd1;
      end else begin
        rx_cnt_reg <= BIT_CYC - 19'd1;
        if (rx_idx_reg == 4'd0) begin
          if (rx_sync_reg) rx_busy_reg <= 1'b0;  // glitch, not a start
          else             rx_idx_reg  <= 4'd1;
        end else if (rx_idx_reg <= 4'd8) begin
          rx_data_reg <= {rx_sync_reg, rx_data_reg[7:1]};
          rx_idx_reg  <= rx_idx_reg + 4'd1;
        end else begin
          rx_busy_reg  <= 1'b0;
          rx_valid_reg <= rx_sync_reg;  // low stop bit: byte discarded
        end
      end
    end
  end

  // ---------------- 2-entry transmit FIFO ----------------
  logic [7:0] fifo_mem [2];
  logic       fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [1:0] fifo_cnt_reg;
  logic       fifo_push, fifo_pop;
  logic [7:0] fifo_push_data;

  wire fifo_full  = (fifo_cnt_reg == 2'd2);
  wire fifo_empty = (fifo_cnt_reg == 2'd0);
  wire push_ok    = fifo_push & ~fifo_full;
  wire pop_ok     = fifo_pop & ~fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         fifo_mem[gi] <= '0;
        else if (push_ok && (fifo_wr_ptr_reg == gi[0]))   fifo_mem[gi] <= fifo_push_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_cnt_reg    <= 2'd0;
    end else begin
      if (push_ok) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
      if (pop_ok)  fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      if (push_ok && !pop_ok)      fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
      else if (pop_ok && !push_ok) fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
    end
  end

  // ---------------- transmitter ----------------
  logic        tx_busy_reg;
  logic [18:0] tx_cnt_reg;
  logic [3:0]  tx_idx_reg;
  logic [8:0]  tx_shift_reg;  // remaining data bits plus stop bit

  // Reload straight from the end of a stop bit so frames run back-to-back.
  wire tx_last = tx_busy_reg && (tx_cnt_reg == '0) && (tx_idx_reg == 4'd9);
  assign fifo_pop = ~fifo_empty & (~tx_busy_reg | tx_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_o         <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '1;
    end else if (fifo_pop) begin
      tx_o         <= 1'b0;
      tx_busy_reg  <= 1'b1;
      tx_cnt_reg   <= BIT_CYC - 19'd1;
      tx_idx_reg   <= 4'd0;
      tx_shift_reg <= {1'b1, fifo_mem[fifo_rd_ptr_reg]};
    end else if (tx_busy_reg) begin
      if (tx_cnt_reg != '0) begin
        tx_cnt_reg <= tx_cnt_reg - 19'd1;
      end else if (tx_idx_reg == 4'd9) begin
        tx_busy_reg <= 1'b0;
      end else begin
        tx_o         <= tx_shift_reg[0];
        tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
        tx_idx_reg   <= tx_idx_reg + 4'd1;
        tx_cnt_reg   <= BIT_CYC - 19'd1;
      end
    end
  end

  // ---------------- packet parser / ALU ----------------
  logic [2:0]  state_reg, state_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  len_lo_reg, len_lo_next;
  logic [15:0] remain_reg, remain_next;
  logic [31:0] acc_reg, acc_next;
  logic [23:0] opnd_reg, opnd_next;  // first three bytes of current operand
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [1:0]  res_idx_reg, res_idx_next;

  wire        op_mul   = MUL_EN && (opcode_reg == OP_MUL);
  wire        op_arith = (opcode_reg == OP_ADD) || op_mul;
  wire [15:0] total    = {rx_data_reg, len_lo_reg};
  wire [15:0] pay_len  = (total < 16'd4) ? 16'd0 : total - 16'd4;
  wire [31:0] operand  = {rx_data_reg, opnd_reg};
  logic [31:0] combined;

`ifdef UART_ALU_MUL_EN
  assign combined = op_mul ? acc_reg * operand : acc_reg + operand;
`else
  assign combined = acc_reg + operand;
`endif

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    len_lo_next    = len_lo_reg;
    remain_next    = remain_reg;
    acc_next       = acc_reg;
    opnd_next      = opnd_reg;
    byte_idx_next  = byte_idx_reg;
    res_idx_next   = res_idx_reg;
    fifo_push      = 1'b0;
    fifo_push_data = rx_data_reg;
    case (state_reg)
      ST_OPCODE: if (rx_valid_reg) begin
        opcode_next   = rx_data_reg;
        // multiply starts from the identity so an empty product is 1
        acc_next      = (MUL_EN && rx_data_reg == OP_MUL) ? 32'd1 : 32'd0;
        byte_idx_next = 2'd0;
        res_idx_next  = 2'd0;
        state_next    = ST_RSVD;
      end
      ST_RSVD: if (rx_valid_reg) state_next = ST_LEN_LO;
      ST_LEN_LO: if (rx_valid_reg) begin
        len_lo_next = rx_data_reg;
        state_next  = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_valid_reg) begin
        remain_next = pay_len;
        if (pay_len != 16'd0) state_next = ST_PAYLOAD;
        else                  state_next = op_arith ? ST_RESULT : ST_OPCODE;
      end
      ST_PAYLOAD: if (rx_valid_reg) begin
        fifo_push     = (opcode_reg == OP_ECHO);
        opnd_next     = {rx_data_reg, opnd_reg[23:8]};
        byte_idx_next = byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) acc_next = combined;
        remain_next   = remain_reg - 16'd1;
        if (remain_reg == 16'd1) state_next = op_arith ? ST_RESULT : ST_OPCODE;
      end
      ST_RESULT: begin
        fifo_push_data = acc_reg[{res_idx_reg, 3'b000} +: 8];
        if (!fifo_full) begin
          fifo_push    = 1'b1;
          res_idx_next = res_idx_reg + 2'd1;
          if (res_idx_reg == 2'd3) state_next = ST_OPCODE;
        end
      end
      default: state_next = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_OPCODE;
      opcode_reg   <= '0;
      len_lo_reg   <= '0;
      remain_reg   <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      byte_idx_reg <= '0;
      res_idx_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      len_lo_reg   <= len_lo_next;
      remain_reg   <= remain_next;
      acc_reg      <= acc_next;
      opnd_reg     <= opnd_next;
      byte_idx_reg <= byte_idx_next;
      res_idx_reg  <= res_idx_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
module tb_uart_alu_top;

  localparam int BIT = 16;  // clk cycles per UART bit with PRESCALE = 2

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_i = 1'b1;
  logic tx_o;

  uart_alu_top #(.PRESCALE(16'd2)) dut (
    .clk (clk),
    .rst (rst),
    .rx_i(rx_i),
    .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Serial monitor on tx_o: decodes frames into got_q.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_o);
      repeat (BIT / 2) @(negedge clk);
      if (tx_o == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (BIT) @(negedge clk);
        check("stop_bit", {31'd0, tx_o}, 32'd1);
        got_q.push_back(b);
        $display("tx byte %02h", b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_i = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(posedge clk);
    end
    rx_i = ~bad_stop;
    repeat (BIT) @(posedge clk);
    rx_i = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  // Reference model: interprets the packet from its documented rules.
  task automatic build_expected();
    int total, n, nops;
    logic [7:0] op;
    logic [31:0] acc, v;
    exp_q.delete();
    op    = pkt_q[0];
    total = int'(pkt_q[2]) + 256 * int'(pkt_q[3]);
    n     = (total < 4) ? 0 : total - 4;
    nops  = n / 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < n; i++) exp_q.push_back(pkt_q[4 + i]);
    end else if (op == 8'hA0
`ifdef UART_ALU_MUL_EN
                 || op == 8'h88
`endif
                ) begin
      acc = (op == 8'h88) ? 32'd1 : 32'd0;
      for (int k = 0; k < nops; k++) begin
        v = {pkt_q[4 + 4*k + 3], pkt_q[4 + 4*k + 2], pkt_q[4 + 4*k + 1], pkt_q[4 + 4*k]};
        acc = (op == 8'h88) ? acc * v : acc + v;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(acc[8*i +: 8]);
    end
  endtask

  task automatic run_packet(input string name);
    int waited;
    build_expected();
    got_q.delete();
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b0);
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    repeat (500) @(posedge clk);
    $display("packet %s op=%02h sent=%0d expected=%0d received=%0d",
             name, pkt_q[0], pkt_q.size(), exp_q.size(), got_q.size());
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    int n, total, sel;
    // reset state
    repeat (5) @(negedge clk);
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    check("idle_tx", {31'd0, tx_o}, 32'd1);

    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    run_packet("echo");
    pkt_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet("add");
    pkt_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet("add_wrap");
    pkt_q = '{8'h55, 8'h00, 8'h05, 8'h00, 8'h99};
    run_packet("unknown");
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    run_packet("echo_after_unknown");
    pkt_q = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    run_packet("mul");
    pkt_q = '{8'hA0, 8'h00, 8'h02, 8'h00};
    run_packet("add_short_len");

    // reset mid-packet
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset_tx", {31'd0, tx_o}, 32'd1);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
    run_packet("after_reset");

    // frame error: byte with low stop bit must vanish
    send_byte(8'h55, 1'b1);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    run_packet("after_frame_err");

    // randomized packets
    for (int p = 0; p < 14; p++) begin
      pkt_q.delete();
      sel = $urandom_range(0, 3);
      case (sel)
        0: pkt_q.push_back(8'hEC);
        1: pkt_q.push_back(8'hA0);
        2: pkt_q.push_back(8'h88);
        default: begin
          logic [7:0] o;
          o = 8'($urandom_range(0, 255));
          if (o == 8'hEC || o == 8'hA0 || o == 8'h88) o = 8'h12;
          pkt_q.push_back(o);
        end
      endcase
      pkt_q.push_back(8'($urandom_range(0, 255)));
      n = $urandom_range(0, 9);
      total = n + 4;
      if (n == 0 && $urandom_range(0, 1) == 1) total = $urandom_range(0, 3);
      pkt_q.push_back(8'(total));
      pkt_q.push_back(8'(total >> 8));
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      run_packet("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
